// File: rtl/udma_hyper_pkg.sv
// rtl/udma_hyper_pkg.sv - shared types and constants for the HyperBus uDMA TX path
package udma_hyper_pkg;

  typedef enum logic [1:0] {TXF_IDLE, TXF_RUN, TXF_DONE} txf_state_e;

  localparam int unsigned STRB_W = 2;

endpackage

// File: rtl/udma_hyper_txframer_fifo.sv
// rtl/udma_hyper_txframer_fifo.sv - 2-entry data FIFO between word intake and PHY beats
module udma_hyper_txframer_fifo #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO refuses the push even when it pops in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/udma_hyper_txframer.sv
// rtl/udma_hyper_txframer.sv - frames 16-bit TX words into strobed PHY write beats
module udma_hyper_txframer
  import udma_hyper_pkg::*;
#(
  parameter int unsigned TRANS_SIZE = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [TRANS_SIZE-1:0] cfg_len_i,
  input  logic                  cfg_odd_saddr_i,
  input  logic                  cfg_reg_access_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [15:0]           in_data_i,
  output logic                  phy_valid_o,
  input  logic                  phy_ready_i,
  output logic [15:0]           phy_data_o,
  output logic [STRB_W-1:0]     phy_strb_o,
  output logic                  phy_last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned CW = TRANS_SIZE + 1;

  txf_state_e        state_q, state_d;
  logic [CW-1:0]     len_sum;
  logic [CW-1:0]     nb_start;
  logic [CW-1:0]     nb_q;
  logic [CW-1:0]     acc_cnt_q;
  logic [CW-1:0]     out_cnt_q;
  logic              odd_saddr_q;
  logic              end_odd_q;
  logic              reg_acc_q;
  logic              fifo_empty;
  logic              fifo_full;
  logic [15:0]       fifo_data;
  logic              in_fire;
  logic              phy_fire;
  logic              last_beat;
  logic [STRB_W-1:0] strb;

  // One extra counter bit keeps len + odd + 1 from wrapping at max length.
  assign len_sum  = CW'(cfg_len_i) + CW'(cfg_odd_saddr_i);
  assign nb_start = cfg_reg_access_i ? CW'(1) : ((len_sum + CW'(1)) >> 1);

  assign in_ready_o  = (state_q == TXF_RUN) && !fifo_full && (acc_cnt_q < nb_q);
  assign phy_valid_o = (state_q == TXF_RUN) && !fifo_empty;
  assign in_fire     = in_valid_i && in_ready_o;
  assign phy_fire    = phy_valid_o && phy_ready_i;
  assign last_beat   = (out_cnt_q == nb_q - CW'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      TXF_IDLE: if (start_i) state_d = (nb_start == '0) ? TXF_DONE : TXF_RUN;
      TXF_RUN:  if (phy_fire && last_beat) state_d = TXF_DONE;
      TXF_DONE: state_d = TXF_IDLE;
      default:  state_d = TXF_IDLE;
    endcase
    if (abort_i) state_d = TXF_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= TXF_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || abort_i) begin
      nb_q        <= '0;
      acc_cnt_q   <= '0;
      out_cnt_q   <= '0;
      odd_saddr_q <= 1'b0;
      end_odd_q   <= 1'b0;
      reg_acc_q   <= 1'b0;
    end else if (state_q == TXF_IDLE && start_i) begin
      nb_q        <= nb_start;
      acc_cnt_q   <= '0;
      out_cnt_q   <= '0;
      odd_saddr_q <= cfg_odd_saddr_i;
      end_odd_q   <= len_sum[0];
      reg_acc_q   <= cfg_reg_access_i;
    end else begin
      if (in_fire)  acc_cnt_q <= acc_cnt_q + CW'(1);
      if (phy_fire) out_cnt_q <= out_cnt_q + CW'(1);
    end
  end

  udma_hyper_txframer_fifo #(
    .WIDTH (16)
  ) i_fifo (
    .clk_i   (clk_i),
    .flush_i (abort_i | rst_i),
    .push_i  (in_fire),
    .data_i  (in_data_i),
    .pop_i   (phy_fire),
    .data_o  (fifo_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Strobe is derived from the beat index, so the FIFO only carries data.
  always_comb begin
    strb = '1;
    if (!reg_acc_q) begin
      if (out_cnt_q == '0 && odd_saddr_q) strb[0] = 1'b0;
      if (last_beat && end_odd_q)         strb[1] = 1'b0;
    end
  end

  assign phy_data_o = phy_valid_o ? fifo_data : '0;
  assign phy_strb_o = phy_valid_o ? strb : '0;
  assign phy_last_o = phy_valid_o && last_beat;
  assign busy_o     = (state_q != TXF_IDLE);
  assign done_o     = (state_q == TXF_DONE);

endmodule

// File: tb/tb_udma_hyper_txframer.sv
// tb/tb_udma_hyper_txframer.sv - directed vector bench for udma_hyper_txframer
module tb_udma_hyper_txframer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        abort_i;
  logic [15:0] cfg_len_i;
  logic        cfg_odd_saddr_i;
  logic        cfg_reg_access_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] in_data_i;
  logic        phy_valid_o;
  logic        phy_ready_i;
  logic [15:0] phy_data_o;
  logic [1:0]  phy_strb_o;
  logic        phy_last_o;
  logic        busy_o;
  logic        done_o;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [15:0] len;
    logic        odd;
    logic        regacc;
    logic        toggle;
    logic [7:0]  nb;
    logic [1:0]  first_strb;
    logic [1:0]  last_strb;
    logic [7:0]  words;
  } vec_t;

  vec_t vecs [9];

  udma_hyper_txframer #(.TRANS_SIZE(16)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .abort_i          (abort_i),
    .cfg_len_i        (cfg_len_i),
    .cfg_odd_saddr_i  (cfg_odd_saddr_i),
    .cfg_reg_access_i (cfg_reg_access_i),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .in_data_i        (in_data_i),
    .phy_valid_o      (phy_valid_o),
    .phy_ready_i      (phy_ready_i),
    .phy_data_o       (phy_data_o),
    .phy_strb_o       (phy_strb_o),
    .phy_last_o       (phy_last_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_xfer(input logic [15:0] len, input logic odd, input logic regacc);
    @(negedge clk_i);
    cfg_len_i        = len;
    cfg_odd_saddr_i  = odd;
    cfg_reg_access_i = regacc;
    start_i          = 1'b1;
    in_valid_i       = 1'b0;
  endtask

  task automatic run_xfer(input vec_t v);
    int acc, sent, post;
    logic running, done_exp, seen_done, prev_stall, rdy, in_fire, phy_fire;
    logic [15:0] pd;
    logic [1:0]  ps, es;
    acc = 0; sent = 0; post = 0;
    running = 1'b1; done_exp = 1'b0; seen_done = 1'b0; prev_stall = 1'b0;
    pd = '0; ps = '0;
    start_xfer(v.len, v.odd, v.regacc);
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk_i);
      start_i     = 1'b0;
      in_valid_i  = (acc < int'(v.words));
      in_data_i   = 16'(32'h1111 * (acc + 1));
      rdy         = v.toggle ? ~cyc[0] : 1'b1;
      phy_ready_i = rdy;
      #1;
      chk("busy", busy_o, running || done_exp);
      chk("done", done_o, done_exp);
      chk("in_ready", in_ready_o, running && (acc - sent) < 2 && acc < int'(v.nb));
      chk("phy_valid", phy_valid_o, running && (acc - sent) > 0);
      if (prev_stall) begin
        chk("stall_data", phy_data_o, pd);
        chk("stall_strb", phy_strb_o, ps);
      end
      in_fire  = in_valid_i && in_ready_o;
      phy_fire = phy_valid_o && rdy;
      if (phy_fire) begin
        es = 2'b11;
        if (sent == 0) es = v.first_strb;
        else if (sent == int'(v.nb) - 1) es = v.last_strb;
        chk("beat_data", phy_data_o, 32'h1111 * (sent + 1));
        chk("beat_strb", phy_strb_o, es);
        chk("beat_last", phy_last_o, sent == int'(v.nb) - 1);
      end
      if (done_exp) seen_done = 1'b1;
      if (seen_done) post++;
      done_exp   = phy_fire && running && (sent == int'(v.nb) - 1);
      prev_stall = phy_valid_o && !rdy;
      pd = phy_data_o;
      ps = phy_strb_o;
      if (in_fire) acc++;
      if (phy_fire) sent++;
      if (done_exp) running = 1'b0;
      if (post == 3) break;
    end
    in_valid_i = 1'b0;
    chk("accepted", acc, v.nb);
    chk("beats", sent, v.nb);
    chk("done_seen", seen_done, 1);
  endtask

  initial begin
    int sent;
    vecs[0] = '{16'd8,    1'b0, 1'b0, 1'b0, 8'd4, 2'b11, 2'b11, 8'd4};
    vecs[1] = '{16'd5,    1'b1, 1'b0, 1'b0, 8'd3, 2'b10, 2'b11, 8'd3};
    vecs[2] = '{16'd4,    1'b1, 1'b0, 1'b0, 8'd3, 2'b10, 2'b01, 8'd3};
    vecs[3] = '{16'h0020, 1'b0, 1'b1, 1'b0, 8'd1, 2'b11, 2'b11, 8'd2};
    vecs[4] = '{16'd16,   1'b0, 1'b0, 1'b1, 8'd8, 2'b11, 2'b11, 8'd8};
    vecs[5] = '{16'd7,    1'b0, 1'b0, 1'b0, 8'd4, 2'b11, 2'b01, 8'd4};
    vecs[6] = '{16'd3,    1'b1, 1'b0, 1'b1, 8'd2, 2'b10, 2'b11, 8'd2};
    vecs[7] = '{16'd1,    1'b1, 1'b0, 1'b0, 8'd1, 2'b10, 2'b10, 8'd1};
    vecs[8] = '{16'd1,    1'b0, 1'b0, 1'b0, 8'd1, 2'b01, 2'b01, 8'd1};

    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    cfg_len_i = '0; cfg_odd_saddr_i = 1'b0; cfg_reg_access_i = 1'b0;
    in_valid_i = 1'b0; in_data_i = '0; phy_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_outputs", {in_ready_o, phy_valid_o, phy_last_o, busy_o, done_o, phy_strb_o}, 0);
    chk("rst_data", phy_data_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    #1;
    chk("idle_outputs", {in_ready_o, phy_valid_o, phy_last_o, busy_o, done_o, phy_strb_o}, 0);

    for (int i = 0; i < 9; i++) run_xfer(vecs[i]);

    // Zero-length transfer: no beat, single done pulse.
    start_xfer(16'd0, 1'b0, 1'b0);
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    chk("len0_done", done_o, 1);
    chk("len0_valid", phy_valid_o, 0);
    chk("len0_ready", in_ready_o, 0);
    @(negedge clk_i);
    #1;
    chk("len0_done_end", done_o, 0);
    chk("len0_busy_end", busy_o, 0);

    // Abort after two beats of a 16-byte transfer.
    start_xfer(16'd16, 1'b0, 1'b0);
    sent = 0;
    for (int cyc = 0; cyc < 50 && sent < 2; cyc++) begin
      @(negedge clk_i);
      start_i     = 1'b0;
      in_valid_i  = 1'b1;
      in_data_i   = 16'hAB00 + 16'(cyc);
      phy_ready_i = 1'b1;
      #1;
      chk("abort_done_low", done_o, 0);
      if (phy_valid_o) sent++;
    end
    chk("abort_beats_before", sent, 2);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    abort_i    = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    #1;
    chk("abort_busy", busy_o, 0);
    chk("abort_valid", phy_valid_o, 0);
    chk("abort_done", done_o, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      #1;
      chk("abort_quiet", {done_o, busy_o, phy_valid_o}, 0);
    end
    run_xfer('{16'd2, 1'b0, 1'b0, 1'b0, 8'd1, 2'b11, 2'b11, 8'd1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
